// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared constants, FSM encoding and frame helper for the PS/2
// receiver slice (ps2_rx_fifo and ps2_sync_fifo).
//   PS2_EXT_CODE / PS2_BRK_CODE : prefix bytes folded into entry flags
//   ENTRY_W                     : FIFO entry width {ext, brk, code[7:0]}
//   FRAME_BITS                  : start + 8 data + parity + stop
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam int         ENTRY_W      = 10;
  localparam int         FRAME_BITS   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  // Frame is held with the start bit in [0] and the stop bit in [10].
  // Good when start=0, stop=1 and data+parity have odd parity.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo -- show-ahead synchronous FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : push request and data
//   rd_en           : pop request, ignored while empty
//   rd_data         : head entry (zero while empty)
//   full, empty     : occupancy flags
//   drop            : one-cycle strobe, a push was refused because full
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_rd;
  logic             do_wr;

  // Extra pointer MSB separates the full and empty cases.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO succeeds.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign drop  = wr_en && full && !do_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage has no reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- PS/2 keyboard receiver with prefix folding and an output FIFO.
//   clk, rst       : clock, synchronous active-high reset
//   EN             : receive enable (0 aborts a partial frame silently)
//   ps2c, ps2d     : asynchronous PS/2 clock and data lines
//   rd_en          : pop the head entry
//   code, is_ext, is_break, valid, full : FIFO head and status
//   tick           : pulse when an entry is written
//   frame_err      : pulse on parity/start/stop/timeout error
//   overflow       : sticky, a decoded code was dropped (FIFO full)
//   err_count      : saturating error counter, built only when PS2_ERRCNT_EN
//                    is defined, otherwise constant zero
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rd_en,
  output logic [7:0] code,
  output logic       is_ext,
  output logic       is_break,
  output logic       valid,
  output logic       full,
  output logic       tick,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]       FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  // Input synchronisers and clock filter; idle line level is high.
  logic       ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
  logic       filt_q;
  logic [7:0] fcnt_q;
  logic       fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_s1_q <= 1'b1;
      ps2c_s2_q <= 1'b1;
      ps2d_s1_q <= 1'b1;
      ps2d_s2_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
    end else begin
      ps2c_s1_q <= ps2c;
      ps2c_s2_q <= ps2c_s1_q;
      ps2d_s1_q <= ps2d;
      ps2d_s2_q <= ps2d_s1_q;
      // Count consecutive samples that disagree with the filtered level;
      // any agreeing sample restarts the count.
      if (ps2c_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FILT_MAX) begin
        filt_q <= ps2c_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  // Strobe in the cycle the filtered clock is about to go from 1 to 0.
  assign fall = filt_q && !ps2c_s2_q && (fcnt_q == FILT_MAX);

  // Deframer FSM.
  ps2_state_e       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [10:0]      shift_q, shift_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic             push, err;
  logic             tick_q, ferr_q, ovf_q;

  logic [ENTRY_W-1:0] head;
  logic               empty, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      tick_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      tick_q    <= push && !drop;
      ferr_q    <= err;
      ovf_q     <= ovf_q || drop;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    err       = 1'b0;
    if (!EN) begin
      // Partial frame discarded without error; prefix flags are kept.
      state_d = IDLE;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall) begin
            shift_d   = {ps2d_s2_q, shift_q[10:1]};
            bit_cnt_d = 4'd1;
            tmo_d     = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            shift_d   = {ps2d_s2_q, shift_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            tmo_d     = '0;
            if (bit_cnt_q == LAST_BIT) state_d = CHECK;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_MAX) begin
              state_d = IDLE;
              err     = 1'b1;
              ext_d   = 1'b0;
              brk_d   = 1'b0;
            end
          end
        end
        CHECK: begin
          state_d = IDLE;
          if (!frame_ok(shift_q)) begin
            err   = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (shift_q[8:1] == PS2_EXT_CODE) begin
            ext_d = 1'b1;
          end else if (shift_q[8:1] == PS2_BRK_CODE) begin
            brk_d = 1'b1;
          end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  ps2_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({ext_q, brk_q, shift_q[8:1]}),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .drop    (drop)
  );

  assign code      = head[7:0];
  assign is_break  = head[8];
  assign is_ext    = head[9];
  assign valid     = !empty;
  assign tick      = tick_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

`ifdef PS2_ERRCNT_EN
  logic [7:0] errcnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt_q <= '0;
    end else if ((err || drop) && errcnt_q != 8'hFF) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end
  assign err_count = errcnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int FL   = 8;
  localparam int FD   = 8;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       EN = 1'b1;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] code;
  logic       is_ext, is_break, valid, full, tick, frame_err, overflow;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int ferr_cnt = 0;
  int exp_err  = 0;
  logic [9:0] sb[$];

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .EN(EN), .ps2d(ps2d), .ps2c(ps2c), .rd_en(rd_en),
    .code(code), .is_ext(is_ext), .is_break(is_break), .valid(valid),
    .full(full), .tick(tick), .frame_err(frame_err), .overflow(overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick) tick_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      repeat (HALF) @(posedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    send_bits(fr, 11);
    repeat (10) @(posedge clk);
  endtask

  task automatic check_err_count(input string tag);
`ifdef PS2_ERRCNT_EN
    check(tag, {24'd0, err_count}, (exp_err > 255) ? 32'd255 : 32'(exp_err));
`else
    check(tag, {24'd0, err_count}, 32'd0);
`endif
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] exp;
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_entry"}, {22'd0, is_ext, is_break, code}, {22'd0, exp});
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_outs"},
          {20'd0, code, is_ext, is_break, valid, full, tick, frame_err, overflow, 1'b0},
          32'd0);
    check({tag, "_errcnt"}, {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    int t0, f0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Plain make code
    t0 = tick_cnt;
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'h1C, 1'b0);
    check("t1_tick", 32'(tick_cnt - t0), 32'd1);
    pop_check("t1");
    check("t1_empty_after_pop", {31'd0, valid}, 32'd0);

    // Extended break sequence, then plain repeat
    t0 = tick_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    sb.push_back({2'b11, 8'h75});
    send_byte(8'h75, 1'b0);
    sb.push_back({2'b00, 8'h75});
    send_byte(8'h75, 1'b0);
    check("t2_ticks", 32'(tick_cnt - t0), 32'd2);
    pop_check("t2a");
    pop_check("t2b");

    // Parity error
    t0 = tick_cnt; f0 = ferr_cnt;
    send_byte(8'h1C, 1'b1);
    exp_err++;
    check("t3_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("t3_no_tick", 32'(tick_cnt - t0), 32'd0);
    check("t3_valid", {31'd0, valid}, 32'd0);
    check_err_count("t3_errcnt");

    // Timeout after 5 bits
    f0 = ferr_cnt;
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    repeat (TMO + 200) @(posedge clk);
    exp_err++;
    check("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
    check_err_count("t4_errcnt");
    sb.push_back({2'b00, 8'h29});
    send_byte(8'h29, 1'b0);
    pop_check("t4");

    // Two-cycle clock glitch must not start a frame
    f0 = ferr_cnt;
    @(posedge clk);
    ps2c = 1'b0;
    repeat (2) @(posedge clk);
    ps2c = 1'b1;
    repeat (TMO + 200) @(posedge clk);
    check("t5_glitch_no_err", 32'(ferr_cnt - f0), 32'd0);
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'h1C, 1'b0);
    pop_check("t5");

    // EN=0 ignores frames silently; prefix flag retained across EN low
    t0 = tick_cnt; f0 = ferr_cnt;
    EN = 1'b0;
    send_byte(8'h44, 1'b0);
    check("t6_dis_no_tick", 32'(tick_cnt - t0), 32'd0);
    check("t6_dis_no_err", 32'(ferr_cnt - f0), 32'd0);
    EN = 1'b1;
    send_byte(8'hE0, 1'b0);
    EN = 1'b0;
    repeat (50) @(posedge clk);
    EN = 1'b1;
    sb.push_back({2'b10, 8'h44});
    send_byte(8'h44, 1'b0);
    pop_check("t6");

    // Overflow: FD+1 frames with no reads
    t0 = tick_cnt;
    for (int i = 0; i <= FD; i++) begin
      if (i < FD) sb.push_back({2'b00, 8'(8'h10 + i)});
      send_byte(8'(8'h10 + i), 1'b0);
    end
    exp_err++;
    @(negedge clk);
    check("t7_ticks", 32'(tick_cnt - t0), 32'(FD));
    check("t7_full", {31'd0, full}, 32'd1);
    check("t7_ovf", {31'd0, overflow}, 32'd1);
    check_err_count("t7_errcnt");
    for (int i = 0; i < FD; i++) pop_check("t7_pop");
    check("t7_empty", {31'd0, valid}, 32'd0);
    check("t7_ovf_sticky", {31'd0, overflow}, 32'd1);
    check("t7_not_full", {31'd0, full}, 32'd0);

    // Reset mid-frame with a non-empty FIFO
    send_byte(8'h33, 1'b0);
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4);
    @(negedge clk);
    check("t8_pre_valid", {31'd0, valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("t8_rst");
    rst = 1'b0;
    sb.delete();
    exp_err = 0;
    repeat (5) @(posedge clk);
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'h1C, 1'b0);
    pop_check("t8");
    check_err_count("t8_errcnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
